mips32_fetch_queue: RTL
=======================

Name: mips32_fetch_queue

Overview:
Single-clock instruction fetch front end for the MIPS32 pipeline.
- Generates word addresses into the 1024 x 32 instruction memory (synchronous read).
- Buffers fetched instructions in a prefetch FIFO.
- Presents {IR, NPC} to the ID stage through a valid/ready handshake.
- Handles branch redirects from EX/MEM by flushing and refetching; stops fetching on halt.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >= 2)
RESET_PC, 0, word address fetched first after reset
AW, 10, instruction memory address width (word addressed)

Ports:
clk  in  1  single pipeline clock
rst  in  1  synchronous active-high reset
imem_req  out  1  read request this cycle
imem_addr  out  AW  word address = PC[AW-1:0]
imem_rdata  in  32  instruction word, valid exactly 1 cycle after an imem_req cycle
redirect_valid  in  1  taken branch; refetch from redirect_pc
redirect_pc  in  32  branch target (EX_MEM_ALUOut)
halt  in  1  HLT retired; stop fetching (sticky)
id_valid  out  1  FIFO head holds an instruction
id_ir  out  32  head instruction
id_npc  out  32  head instruction address + 1
id_ready  in  1  ID stage accepts head this cycle

Behaviour:
- Reset (rst=1 on a clk edge): PC=RESET_PC, FIFO empty, inflight=0, state=IDLE. Outputs: imem_req=0, id_valid=0, id_ir=0, id_npc=0. Reset overrides every other input, including mid-flush and while in HALTED.
- FSM states:
  - IDLE: always moves to RUN on the next cycle. imem_req=0.
  - RUN: normal operation.
  - HALTED: entered when halt=1 in RUN. Leaves only on rst.
- Issue rule (RUN only): imem_req=1 when (count + inflight) < DEPTH and redirect_valid=0.
  - imem_addr=PC[AW-1:0].
  - On issue: PC<=PC+1 (32-bit wrap), inflight<=1, and the issued address is captured as req_pc.
  - Sustained rate is 1 fetch/cycle while space exists.
- Response: the cycle after an issue, push {imem_rdata, req_pc+1} unless a kill is pending. Inflight then clears. Latency from imem_req to id_valid is 2 cycles when the FIFO is empty.
- Pop: when id_valid && id_ready, advance the head. Push and pop may occur in the same cycle, and count is unchanged. Overflow is impossible by the issue rule; pushing into a full FIFO is an assertion failure.
- id_valid = (count != 0). id_ir and id_npc are driven from the head entry (registered storage, combinational read of the head). They hold steady while id_valid && !id_ready.
- Redirect (any state except HALTED):
  - Same cycle: FIFO cleared (count=0), any pop that cycle is ignored, PC<=redirect_pc, and no issue.
  - An in-flight response arriving the next cycle is discarded (kill flag).
  - The first fetch of the target is issued the cycle after the redirect.
- Redirect has priority over halt, push and pop in the same cycle. A redirect in HALTED is ignored.
- Halt:
  - Issuing stops the same cycle halt is sampled.
  - An in-flight response is still pushed.
  - The FIFO keeps draining to ID.
  - PC is frozen.
- Counter widths: count is log2(DEPTH)+1 bits; the FIFO read and write pointers wrap modulo DEPTH.

Test Plan:
1. Straight-line fetch: reset with RESET_PC=0, imem holds word k = 0x1000_0000+k, id_ready=1 -> first id_valid 3 cycles after rst deasserts (IDLE, issue, push); id_ir=0x1000_0000, id_npc=1, then 0x1000_0001/2, ... one per cycle, with no gaps.
2. Backpressure: id_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req=0 after the 4th issue, id_ir stable at 0x1000_0000. Release id_ready -> words 0..7 delivered in order, with no loss or duplication.
3. Redirect with in-flight fetch: FIFO holds words 2,3 and word 4 is in flight; pulse redirect_valid with redirect_pc=0x20 -> id_valid=0 the next cycle, word 4 never appears, next id_ir=Mem[0x20] with id_npc=0x21.
4. Redirect while full with id_ready=1 the same cycle -> the head is not counted as consumed, the FIFO is empty, and the next delivered id_npc=redirect_pc+1.
5. Halt: assert halt after word 5 is issued -> no further imem_req, words up to 5 drain to ID, then id_valid=0 permanently. A redirect_valid in HALTED has no effect. rst returns the block to IDLE and fetching restarts from 0.
6. Address wrap: RESET_PC=0x3FE -> imem_addr sequence 0x3FE, 0x3FF, 0x000, with id_npc = 0x3FF, 0x400, 0x401.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
// MIPS32 fetch front end: PC generation, sync-read imem requests,
// prefetch FIFO and {IR,NPC} valid/ready hand-off to the ID stage.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   word-address read request (PC[AW-1:0])
//   imem_rdata      instruction word, valid 1 cycle after imem_req
//   redirect_valid  taken branch from EX/MEM, refetch from redirect_pc
//   halt            HLT retired, stop fetching until reset
//   id_valid/ready  handshake with ID; id_ir/id_npc are the FIFO head
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          id_valid,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc,
  input  logic          id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic [31:0]   ir_q  [DEPTH];
  logic [31:0]   npc_q [DEPTH];

  logic flush;
  logic issue;
  logic push;
  logic pop;

  // A redirect empties the queue; the response in flight during the
  // redirect cycle belongs to the old path and is dropped with it.
  assign flush = redirect_valid && (state != HALTED);

  // Space is reserved for the outstanding response, so the queue can
  // never be pushed while full.
  assign occ   = count + CW'(inflight);
  assign issue = (state == RUN) && !redirect_valid && !halt &&
                 (occ < CW'(DEPTH));
  assign push  = inflight && !flush;
  assign pop   = id_valid && id_ready && !flush;

  assign imem_req  = issue;
  assign imem_addr = pc[AW-1:0];

  assign id_valid = (count != '0);
  assign id_ir    = id_valid ? ir_q[rptr]  : 32'h0;
  assign id_npc   = id_valid ? npc_q[rptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      unique case (state)
        IDLE:    state <= RUN;
        RUN:     if (halt && !redirect_valid) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
      inflight <= issue;
      if (flush) begin
        pc    <= redirect_pc;
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (issue) begin
          pc     <= pc + 32'd1;
          req_pc <= pc;
        end
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_q[wptr]  <= imem_rdata;
      npc_q[wptr] <= req_pc + 32'd1;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH))
  );

endmodule
